// File: rtl/vit_fixed_pkg.sv
// Shared Q1.15 fixed-point definitions for the ViT datapath blocks.
package vit_fixed_pkg;

    localparam int Q15_WIDTH  = 16;
    localparam int FRAC_SHIFT = 15;

    typedef logic signed [Q15_WIDTH-1:0] q15_t;

    localparam q15_t Q15_MAX = 16'sh7FFF;
    localparam q15_t Q15_MIN = 16'sh8000;

    // Clamp a wide signed value into the Q1.15 range.
    function automatic q15_t sat16(input logic signed [63:0] x);
        q15_t r;
        if (x > 64'sd32767)
            r = Q15_MAX;
        else if (x < -64'sd32768)
            r = Q15_MIN;
        else
            r = q15_t'(x[Q15_WIDTH-1:0]);
        return r;
    endfunction

endpackage

// File: rtl/patch_dot_unit.sv
// Combinational P-term signed dot product; full-precision products summed
// into an accumulator wide enough that no partial sum can overflow.
module patch_dot_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int P          = 16,
    parameter int ACC_W      = 2*DATA_WIDTH + $clog2(P) + 2
) (
    input  logic signed [DATA_WIDTH-1:0] i_samples [0:P-1],
    input  logic signed [DATA_WIDTH-1:0] i_weights [0:P-1],
    output logic signed [ACC_W-1:0]      o_sum
);

    logic signed [2*DATA_WIDTH-1:0] w_prod [0:P-1];

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_mul
            assign w_prod[gi] = (2*DATA_WIDTH)'(i_samples[gi]) * (2*DATA_WIDTH)'(i_weights[gi]);
        end
    endgenerate

    // NOTE: the running sum is a combinational chain, so it uses blocking '='
    // to read each partial result in the same pass; clocked state uses '<='.
    always_comb begin
        o_sum = '0;
        for (int p = 0; p < P; p++)
            o_sum = o_sum + ACC_W'(w_prod[p]);
    end

endmodule

// File: rtl/patch_embedding.sv
// Patch embedding: one output element (patch n, dim e) per cycle from a P-wide
// dot product plus bias and positional term, saturated to Q1.15.
module patch_embedding
    import vit_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int P          = 16,
    parameter int E          = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] patch_in      [0:N*P-1],
    input  logic signed [DATA_WIDTH-1:0] W_pe_in       [0:P*E-1],
    input  logic signed [DATA_WIDTH-1:0] b_pe_in       [0:E-1],
    input  logic signed [DATA_WIDTH-1:0] pos_emb_in    [0:N*E-1],
    output logic signed [DATA_WIDTH-1:0] patch_emb_out [0:N*E-1],
    output logic                         out_valid,
    output logic                         busy
);

    localparam int NE    = N * E;
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(P) + 2;
    localparam int IDX_W = (NE > 1)    ? $clog2(NE)    : 1;
    localparam int N_W   = (N > 1)     ? $clog2(N)     : 1;
    localparam int E_W   = (E > 1)     ? $clog2(E)     : 1;
    localparam int PIX_W = (N*P > 1)   ? $clog2(N*P)   : 1;
    localparam int WGT_W = (P*E > 1)   ? $clog2(P*E)   : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]                  r_state;
    logic [IDX_W-1:0]            r_idx;
    logic [N_W-1:0]              r_n;
    logic [E_W-1:0]              r_e;
    logic                        r_busy;
    logic                        r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out [0:NE-1];

    logic signed [DATA_WIDTH-1:0] w_samples [0:P-1];
    logic signed [DATA_WIDTH-1:0] w_weights [0:P-1];
    logic signed [ACC_W-1:0]      w_dot;
    logic signed [ACC_W-1:0]      w_acc;
    logic signed [ACC_W-1:0]      w_shifted;
    q15_t                         w_sat;

    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_samples = '{default: '0};
        w_weights = '{default: '0};
        for (int p = 0; p < P; p++) begin
            w_samples[p] = patch_in[PIX_W'(r_n) * PIX_W'(P) + PIX_W'(p)];
            w_weights[p] = W_pe_in[WGT_W'(p) * WGT_W'(E) + WGT_W'(r_e)];
        end
    end

    patch_dot_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .P          (P),
        .ACC_W      (ACC_W)
    ) u_dot (
        .i_samples (w_samples),
        .i_weights (w_weights),
        .o_sum     (w_dot)
    );

    // Bias and positional terms are sign-extended to full width before scaling.
    assign w_acc     = w_dot
                     + (ACC_W'(b_pe_in[r_e])        <<< FRAC_SHIFT)
                     + (ACC_W'(pos_emb_in[r_idx])   <<< FRAC_SHIFT);
    assign w_shifted = w_acc >>> FRAC_SHIFT;
    assign w_sat     = sat16(64'(w_shifted));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_n         <= '0;
            r_e         <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= COMPUTE;
                        r_idx   <= '0;
                        r_n     <= '0;
                        r_e     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (r_idx == IDX_W'(NE - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_e == E_W'(E - 1)) begin
                            r_e <= '0;
                            r_n <= r_n + N_W'(1);
                        end else begin
                            r_e <= r_e + E_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the output array is architecturally visible and must read zero
    // straight out of reset, so unlike a scratch RAM it carries a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++)
                r_out[i] <= '0;
        end else if (r_state == COMPUTE) begin
            r_out[r_idx] <= DATA_WIDTH'(w_sat);
        end
    end

    assign patch_emb_out = r_out;
    assign out_valid     = r_out_valid;
    assign busy          = r_busy;

endmodule
